// File: rtl/flex_bit_timer.sv
// ---------------------------------------------------------------------------
// flex_bit_timer
// Bit/packet timing controller for the serial receiver datapath.
// Emits a one-cycle shift_strobe every P clocks and a packet_done pulse
// together with the B-th strobe. P and B are sampled from bit_period and
// packet_bits when a packet starts and held for the whole packet.
// Dropping enable_timer during a packet aborts it without any strobe.
//
// Optional feature macro: FLEX_TIMER_HALF_BIT_EN
//   When defined, the first bit interval of every packet is P + (P >> 1)
//   clocks so that sampling lands mid-bit after start-edge detection.
//
// Ports:
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   enable_timer  level: high starts/continues a packet, low aborts
//   bit_period    clocks per bit (0 treated as 1), sampled at packet start
//   packet_bits   bits per packet (0 treated as 1), sampled at packet start
//   shift_strobe  one-cycle pulse at each bit boundary (registered)
//   packet_done   one-cycle pulse with the final strobe (registered)
//   bit_index     strobes issued in the current packet (registered)
//   busy          high while a packet is being timed (registered)
// ---------------------------------------------------------------------------
module flex_bit_timer #(
    parameter int CNT_WIDTH = 8,
    parameter int BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 enable_timer,
    input  logic [CNT_WIDTH-1:0] bit_period,
    input  logic [BIT_WIDTH-1:0] packet_bits,
    output logic                 shift_strobe,
    output logic                 packet_done,
    output logic [BIT_WIDTH-1:0] bit_index,
    output logic                 busy
);

`ifdef FLEX_TIMER_HALF_BIT_EN
    // One extra bit so P + P/2 cannot overflow the clock counter.
    localparam int CW = CNT_WIDTH + 1;
`else
    localparam int CW = CNT_WIDTH;
`endif

    localparam logic [CNT_WIDTH-1:0] P_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BIT_WIDTH-1:0] B_ONE   = {{(BIT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]        CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t               state_r, state_s;
    logic [CNT_WIDTH-1:0] p_r, p_s;
    logic [BIT_WIDTH-1:0] b_r, b_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [CW-1:0]        thr_s;
    logic [BIT_WIDTH-1:0] idx_r, idx_s;
    logic [BIT_WIDTH-1:0] idx_inc_s;
    logic                 strobe_r, strobe_s;
    logic                 done_r, done_s;
    logic                 busy_r, busy_s;

    // Terminal count for the current bit interval.
    always_comb begin
        thr_s = {CW{1'b0}};
`ifdef FLEX_TIMER_HALF_BIT_EN
        // No strobe issued yet means we are still in the stretched first bit.
        if (idx_r == {BIT_WIDTH{1'b0}}) begin
            thr_s = {1'b0, p_r} + {2'b00, p_r[CNT_WIDTH-1:1]};
        end else begin
            thr_s = {1'b0, p_r};
        end
`else
        thr_s = p_r;
`endif
    end

    // Next-state and next-output logic for the packet FSM.
    always_comb begin
        state_s   = state_r;
        p_s       = p_r;
        b_s       = b_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        busy_s    = busy_r;
        strobe_s  = 1'b0;
        done_s    = 1'b0;
        idx_inc_s = idx_r + B_ONE;
        case (state_r)
            IDLE: begin
                if (enable_timer) begin
                    state_s = COUNT;
                    p_s     = (bit_period == {CNT_WIDTH{1'b0}}) ? P_ONE : bit_period;
                    b_s     = (packet_bits == {BIT_WIDTH{1'b0}}) ? B_ONE : packet_bits;
                    cnt_s   = CNT_ONE;
                    idx_s   = {BIT_WIDTH{1'b0}};
                    busy_s  = 1'b1;
                end else begin
                    // bit_index keeps the last packet's count while idle.
                    state_s = IDLE;
                end
            end
            COUNT: begin
                if (!enable_timer) begin
                    // Abort wins over any strobe due on this edge.
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                    idx_s   = {BIT_WIDTH{1'b0}};
                    busy_s  = 1'b0;
                end else if (cnt_r == thr_s) begin
                    cnt_s    = CNT_ONE;
                    idx_s    = idx_inc_s;
                    strobe_s = 1'b1;
                    if (idx_inc_s == b_r) begin
                        done_s  = 1'b1;
                        state_s = IDLE;
                        busy_s  = 1'b0;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        state_s = COUNT;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
                idx_s   = {BIT_WIDTH{1'b0}};
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, configuration, counter and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r  <= IDLE;
            p_r      <= {CNT_WIDTH{1'b0}};
            b_r      <= {BIT_WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            idx_r    <= {BIT_WIDTH{1'b0}};
            strobe_r <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            p_r      <= p_s;
            b_r      <= b_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            strobe_r <= strobe_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
        end
    end

    assign shift_strobe = strobe_r;
    assign packet_done  = done_r;
    assign bit_index    = idx_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_flex_bit_timer.sv
// ---------------------------------------------------------------------------
// tb_flex_bit_timer
// Directed self-checking bench for flex_bit_timer. Edges are numbered from
// the packet's edge 0; outputs are sampled 1 time unit after each rising
// edge. Expected strobe positions come from closed-form timing:
// first strobe at edge F (F = P, or P + P/2 with FLEX_TIMER_HALF_BIT_EN),
// subsequent strobes every P edges, packet ends at F + (B-1)*P.
// ---------------------------------------------------------------------------
module tb_flex_bit_timer;

    logic       clk;
    logic       n_rst;
    logic       enable_timer;
    logic [7:0] bit_period;
    logic [3:0] packet_bits;
    logic       shift_strobe;
    logic       packet_done;
    logic [3:0] bit_index;
    logic       busy;

    int checks;
    int failures;

    flex_bit_timer #(.CNT_WIDTH(8), .BIT_WIDTH(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable_timer (enable_timer),
        .bit_period   (bit_period),
        .packet_bits  (packet_bits),
        .shift_strobe (shift_strobe),
        .packet_done  (packet_done),
        .bit_index    (bit_index),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs after edge e of a packet with raw settings p, b.
    task automatic check_edge(input int p, input int b, input int e);
        int pe, be, first, last, exp_strobe, exp_idx;
        pe = (p == 0) ? 1 : p;
        be = (b == 0) ? 1 : b;
`ifdef FLEX_TIMER_HALF_BIT_EN
        first = pe + pe / 2;
`else
        first = pe;
`endif
        last = first + (be - 1) * pe;
        exp_strobe = (e >= first && e <= last && ((e - first) % pe) == 0) ? 1 : 0;
        exp_idx    = (e < first) ? 0 : 1 + (e - first) / pe;
        chk($sformatf("strobe_e%0d", e), int'(shift_strobe), exp_strobe);
        chk($sformatf("done_e%0d", e), int'(packet_done), (e == last) ? 1 : 0);
        chk($sformatf("busy_e%0d", e), int'(busy), (e < last) ? 1 : 0);
        chk($sformatf("index_e%0d", e), int'(bit_index), exp_idx);
    endtask

    function automatic int last_edge(input int p, input int b);
        int pe, be;
        pe = (p == 0) ? 1 : p;
        be = (b == 0) ? 1 : b;
`ifdef FLEX_TIMER_HALF_BIT_EN
        return pe + pe / 2 + (be - 1) * pe;
`else
        return be * pe;
`endif
    endfunction

    // Full packet with enable held high; optional bit_period change after edge chg_edge.
    task automatic run_packet(input int p, input int b, input int chg_edge, input int chg_val);
        int last;
        last         = last_edge(p, b);
        bit_period   = p[7:0];
        packet_bits  = b[3:0];
        enable_timer = 1'b1;
        tick();
        check_edge(p, b, 0);
        for (int e = 1; e <= last; e++) begin
            tick();
            check_edge(p, b, e);
            if (e == chg_edge) begin
                bit_period = chg_val[7:0];
            end
        end
    endtask

    // Packet aborted by enable low sampled at edge ae.
    task automatic run_abort(input int p, input int b, input int ae);
        bit_period   = p[7:0];
        packet_bits  = b[3:0];
        enable_timer = 1'b1;
        tick();
        check_edge(p, b, 0);
        for (int e = 1; e < ae; e++) begin
            tick();
            check_edge(p, b, e);
        end
        enable_timer = 1'b0;
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_index", int'(bit_index), 0);
        chk("abort_strobe", int'(shift_strobe), 0);
        chk("abort_done", int'(packet_done), 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post_abort_strobe", int'(shift_strobe), 0);
            chk("post_abort_busy", int'(busy), 0);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        n_rst        = 1'b0;
        enable_timer = 1'b1;
        bit_period   = 8'd10;
        packet_bits  = 4'd9;

        // 1. Reset held with enable high and clock running.
        repeat (3) tick();
        chk("rst_strobe", int'(shift_strobe), 0);
        chk("rst_done", int'(packet_done), 0);
        chk("rst_index", int'(bit_index), 0);
        chk("rst_busy", int'(busy), 0);
        n_rst = 1'b1;

        // 2. P=10, B=9 starting on the first edge after reset release.
        run_packet(10, 9, 0, 0);
        enable_timer = 1'b0;
        tick();
        chk("idle_hold_index", int'(bit_index), 9);
        chk("idle_busy", int'(busy), 0);
        chk("idle_strobe", int'(shift_strobe), 0);
        tick();
        chk("idle_hold_index2", int'(bit_index), 9);

        // 3. Abort at edge 35, then fresh restart; abort on a strobe edge.
        run_abort(10, 9, 35);
        run_packet(3, 2, 0, 0);
        enable_timer = 1'b0;
        tick();
        run_abort(10, 9, 40);

        // 4. P=1 strobes every cycle, then back-to-back P=0/B=0 clamp.
        run_packet(1, 3, 0, 0);
        run_packet(0, 0, 0, 0);
        enable_timer = 1'b0;
        tick();
        chk("clamp_idle_index", int'(bit_index), 1);

        // 5. Mid-packet bit_period change ignored; next packet uses P=4.
        run_packet(10, 2, 15, 4);
        run_packet(4, 2, 0, 0);
        enable_timer = 1'b0;
        tick();
        chk("final_busy", int'(busy), 0);
        chk("final_index", int'(bit_index), 2);

        // 6. Mid-packet reset clears everything asynchronously.
        run_abort(5, 4, 3);
        enable_timer = 1'b1;
        tick();
        tick();
        chk("pre_rst_busy", int'(busy), 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_index", int'(bit_index), 0);
        n_rst        = 1'b1;
        enable_timer = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
